// File: rtl/regfile_bram_multi.sv
// -----------------------------------------------------------------------------
// regfile_bram_multi
//
// Block-RAM register file for the risc8 core with NUM_RD registered read
// ports and one byte / aligned-pair write port. Registers are stored as
// NUM_REGS/2 pair-words split into a low lane (even register) and a high lane
// (odd register). Each read port has its own RAM copy, and every write goes
// to all copies. A clear sequencer zeroes every pair-word after reset or on
// clear_req, so the RAMs need no initialisation file.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low
//   clear_req  pulse while ready=1 starts a clear sweep
//   ready      1 = reads/writes valid, 0 = clearing (writes dropped)
//   dbg_state  current sequencer state (ST_CLEAR / ST_READY)
//   rd_addr    per-port register address, port p at [p*ADDR_W +: ADDR_W]
//   rd_word    per-port pair-read enable
//   rd_data    per-port result, port p at [p*2*DATA_W +: 2*DATA_W]
//   wr_en      write strobe
//   wr_word    1 = write register pair, 0 = single register
//   wr_addr    write address (bit 0 ignored for pair writes)
//   wr_data    write data (byte writes use the low DATA_W bits)
//
// Interface timing: ready is a level, not a handshake. Whenever ready=1, a
// read address presented before an edge yields rd_data after that edge, held
// for one cycle. A write with wr_en=1 commits at the edge. While ready=0 the
// writes are discarded and rd_data is zero.
// -----------------------------------------------------------------------------
module regfile_bram_multi #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         ready,
  output logic [0:0]                   dbg_state,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  input  logic [NUM_RD-1:0]            rd_word,
  output logic [NUM_RD*2*DATA_W-1:0]   rd_data,
  input  logic                         wr_en,
  input  logic                         wr_word,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [2*DATA_W-1:0]          wr_data
);

  localparam int NUM_WORDS = NUM_REGS / 2;
  localparam int WA_W      = ADDR_W - 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]      r_state;
  logic [WA_W-1:0] r_clr_idx;
  logic [DATA_W-1:0] r_wd_lo;
  logic [DATA_W-1:0] r_wd_hi;

  logic              w_in_ready;
  logic              w_wr_commit;
  logic [WA_W-1:0]   w_wa;
  logic              w_we_lo;
  logic              w_we_hi;
  logic [DATA_W-1:0] w_wd_lo;
  logic [DATA_W-1:0] w_wd_hi;
  logic              w_clr_we;
  logic [WA_W-1:0]   w_ram_addr;
  logic              w_ram_we_lo;
  logic              w_ram_we_hi;
  logic [DATA_W-1:0] w_ram_d_lo;
  logic [DATA_W-1:0] w_ram_d_hi;

  assign w_in_ready  = (r_state == ST_READY);
  assign ready       = w_in_ready;
  assign dbg_state   = r_state;

  // User write lane enables. A byte write to an odd register lands in the
  // high lane but still takes its data from wr_data[DATA_W-1:0].
  assign w_wr_commit = w_in_ready & wr_en;
  assign w_wa        = wr_addr[ADDR_W-1:1];
  assign w_we_lo     = w_wr_commit & (wr_word | ~wr_addr[0]);
  assign w_we_hi     = w_wr_commit & (wr_word |  wr_addr[0]);
  assign w_wd_lo     = wr_data[DATA_W-1:0];
  assign w_wd_hi     = wr_word ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];

  // The sweep owns the RAM write port while clearing. It is held off during
  // reset so the sweep starts cleanly at index 0 on release.
  assign w_clr_we    = ~w_in_ready & reset;
  assign w_ram_addr  = w_clr_we ? r_clr_idx : w_wa;
  assign w_ram_we_lo = w_clr_we | w_we_lo;
  assign w_ram_we_hi = w_clr_we | w_we_hi;
  assign w_ram_d_lo  = w_clr_we ? '0 : w_wd_lo;
  assign w_ram_d_hi  = w_clr_we ? '0 : w_wd_hi;

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == WA_W'(NUM_WORDS - 1)) begin
            r_state   <= ST_READY;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
          end
        end
      endcase
    end
  end

  // Registered copy of the lane write data used for forwarding. It is shared
  // by all ports.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd_lo <= '0;
      r_wd_hi <= '0;
    end else begin
      r_wd_lo <= w_wd_lo;
      r_wd_hi <= w_wd_hi;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [DATA_W-1:0] mem_lo [NUM_WORDS];
    logic [DATA_W-1:0] mem_hi [NUM_WORDS];

    logic [DATA_W-1:0]   r_ram_lo;
    logic [DATA_W-1:0]   r_ram_hi;
    logic                r_valid;
    logic                r_word;
    logic                r_odd;
    logic                r_fwd_lo;
    logic                r_fwd_hi;

    logic [WA_W-1:0]     w_ra;
    logic                w_ra_odd;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_hi;
    logic [2*DATA_W-1:0] w_out;

    assign w_ra     = rd_addr[p*ADDR_W+1 +: WA_W];
    assign w_ra_odd = rd_addr[p*ADDR_W];

    // Simple dual-port RAM. The read returns the pre-write contents, and a
    // same-edge collision is handled by the forwarding selects below.
    always_ff @(posedge clk) begin
      if (w_ram_we_lo) mem_lo[w_ram_addr] <= w_ram_d_lo;
      if (w_ram_we_hi) mem_hi[w_ram_addr] <= w_ram_d_hi;
      r_ram_lo <= mem_lo[w_ra];
      r_ram_hi <= mem_hi[w_ra];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_valid  <= 1'b0;
        r_word   <= 1'b0;
        r_odd    <= 1'b0;
        r_fwd_lo <= 1'b0;
        r_fwd_hi <= 1'b0;
      end else begin
        r_valid  <= w_in_ready;
        r_word   <= rd_word[p];
        r_odd    <= w_ra_odd;
        r_fwd_lo <= w_we_lo & (w_ra == w_wa);
        r_fwd_hi <= w_we_hi & (w_ra == w_wa);
      end
    end

    assign w_lo = r_fwd_lo ? r_wd_lo : r_ram_lo;
    assign w_hi = r_fwd_hi ? r_wd_hi : r_ram_hi;

    // An odd address always returns the high lane alone. A pair read is only
    // honoured at an even address.
    always_comb begin
      w_out = '0;
      if (r_valid) begin
        if (r_odd)       w_out = {{DATA_W{1'b0}}, w_hi};
        else if (r_word) w_out = {w_hi, w_lo};
        else             w_out = {{DATA_W{1'b0}}, w_lo};
      end
    end

    assign rd_data[p*2*DATA_W +: 2*DATA_W] = w_out;
  end

endmodule

// File: tb/tb_regfile_bram_multi.sv
module tb_regfile_bram_multi;

  localparam int DW  = 8;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic                  clk       = 1'b0;
  logic                  reset     = 1'b0;
  logic                  clear_req = 1'b0;
  logic                  ready;
  logic [0:0]            dbg_state;
  logic [NRD*AW-1:0]     rd_addr   = '0;
  logic [NRD-1:0]        rd_word   = '0;
  logic [NRD*2*DW-1:0]   rd_data;
  logic                  wr_en     = 1'b0;
  logic                  wr_word   = 1'b0;
  logic [AW-1:0]         wr_addr   = '0;
  logic [2*DW-1:0]       wr_data   = '0;

  // Per-port "read issued" flags, delayed one edge to mark when rd_data is due
  logic [NRD-1:0]        rd_chk    = '0;
  logic [NRD-1:0]        chk_d     = '0;
  logic [2*DW-1:0]       exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  regfile_bram_multi #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .ready     (ready),
    .dbg_state (dbg_state),
    .rd_addr   (rd_addr),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) chk_d <= rd_chk;

  // Scoreboard monitor: pops one expected value per port that has a result due
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      if (chk_d[p]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd port%0d: got %h expected nothing (queue empty)", p,
                   rd_data[p*2*DW +: 2*DW]);
        end else begin
          check($sformatf("rd port%0d", p), 32'(rd_data[p*2*DW +: 2*DW]),
                32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    rd_chk    = '0;
    rd_word   = '0;
    wr_en     = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic w, input logic [2*DW-1:0] e);
    rd_addr[p*AW +: AW] = a;
    rd_word[p]          = w;
    rd_chk[p]           = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic w, input logic [2*DW-1:0] d);
    wr_en   = 1'b1;
    wr_word = w;
    wr_addr = a;
    wr_data = d;
  endtask

  // Counts edges until ready is seen high, bounded
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check("reset ready", 32'(ready), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);

    // Initial sweep length
    reset = 1'b1;
    wait_ready(cnt);
    check("sweep cycles", cnt, 32'd16);

    // Reset pulled mid-sweep restarts it
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (7) step();
    reset = 1'b0;
    step();
    check("mid reset ready", 32'(ready), 32'd0);
    step();
    reset = 1'b1;
    wait_ready(cnt);
    check("restart sweep cycles", cnt, 32'd16);

    // Every pair reads zero after the sweep
    for (int i = 0; i < 8; i++) begin
      rd(0, AW'(4 * i), 1'b1, 16'h0000);
      rd(1, AW'(4 * i + 2), 1'b1, 16'h0000);
      step();
    end

    // Byte writes then reads from RAM
    wr(5, 1'b0, 16'h00A5); step();
    wr(4, 1'b0, 16'h003C); step();
    rd(0, 4, 1'b1, 16'hA53C);
    rd(1, 5, 1'b0, 16'h00A5);
    wr(9, 1'b0, 16'h0077);                 // unrelated write, no forwarding
    step();
    wr(10, 1'b0, 16'h0088);
    rd(0, 8, 1'b1, 16'h7700);
    step();

    // Odd pair read
    rd(0, 9, 1'b1, 16'h0077);
    rd(1, 10, 1'b0, 16'h0088);
    step();

    // Word write forwarded to both ports, then same reads from RAM
    wr(24, 1'b1, 16'hBEEF);
    rd(0, 24, 1'b1, 16'hBEEF);
    rd(1, 25, 1'b0, 16'h00BE);
    step();
    rd(0, 24, 1'b1, 16'hBEEF);
    rd(1, 25, 1'b0, 16'h00BE);
    step();

    // Mixed forward (high lane) and RAM (low lane)
    wr(16, 1'b1, 16'h2233); step();
    wr(17, 1'b0, 16'h0011);
    rd(0, 16, 1'b1, 16'h1133);
    rd(1, 16, 1'b0, 16'h0033);
    step();

    // Odd byte forward while the neighbour stays RAM data
    wr(7, 1'b0, 16'h005A);
    rd(0, 7, 1'b0, 16'h005A);
    rd(1, 6, 1'b0, 16'h0000);
    step();

    // Both ports reading the same address see the same value
    rd(0, 24, 1'b1, 16'hBEEF);
    rd(1, 24, 1'b1, 16'hBEEF);
    step();

    // Clear request with a simultaneous write that the sweep overwrites
    wr(3, 1'b0, 16'h0055);
    rd(0, 3, 1'b0, 16'h0055);
    clear_req = 1'b1;
    step();
    check("clear ready drop", 32'(ready), 32'd0);
    wr(3, 1'b0, 16'h0066);                 // dropped while clearing
    rd(0, 2, 1'b1, 16'h0000);              // reads zero while clearing
    wait_ready(cnt);
    check("clear sweep cycles", cnt, 32'd16);
    rd(0, 3, 1'b0, 16'h0000);
    rd(1, 2, 1'b1, 16'h0000);
    step();
    rd(0, 24, 1'b1, 16'h0000);
    rd(1, 4, 1'b1, 16'h0000);
    step();

    repeat (3) step();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
